// File: rtl/custom_instr_dispatcher_pkg.sv
// rtl/custom_instr_dispatcher_pkg.sv - shared state encoding and constants for the dispatcher
package custom_instr_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } cid_state_e;

  localparam logic [31:0] CID_ERR_DATA = 32'hDEAD_BEEF;

  // Slot-select field sits at the top of the 10-bit function ID.
  localparam int CID_SEL_MSB = 9;

endpackage

// File: rtl/custom_instr_dispatcher_timeout_ctr.sv
// rtl/custom_instr_dispatcher_timeout_ctr.sv - saturating watchdog counter with expire flag
module cid_timeout_ctr #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // Expiry is only meaningful while the watched operation is running.
  assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/custom_instr_dispatcher.sv
// rtl/custom_instr_dispatcher.sv - single-outstanding custom-instruction router with timeout
module custom_instr_dispatcher
  import custom_instr_dispatcher_pkg::*;
#(
  parameter int          NUM_SLV     = 2,
  parameter int          SEL_W       = 1,
  parameter int          TIMEOUT_CYC = 4096,
  parameter logic [31:0] ERR_DATA    = CID_ERR_DATA
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cmd_valid,
  input  logic [9:0]              cmd_function_id,
  input  logic [31:0]             cmd_inputs_0,
  input  logic [31:0]             cmd_inputs_1,
  output logic                    cmd_ready,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_outputs_0,
  input  logic                    rsp_ready,
  output logic [NUM_SLV-1:0]      s_cmd_valid,
  output logic [9:0]              s_cmd_function_id,
  output logic [31:0]             s_cmd_inputs_0,
  output logic [31:0]             s_cmd_inputs_1,
  input  logic [NUM_SLV-1:0]      s_cmd_ready,
  input  logic [NUM_SLV-1:0]      s_rsp_valid,
  input  logic [32*NUM_SLV-1:0]   s_rsp_outputs_0,
  output logic [NUM_SLV-1:0]      s_rsp_ready,
  output logic                    busy,
  output logic                    err_timeout
);

  cid_state_e          state_q, state_d;
  logic [SEL_W-1:0]    cmd_slot, slot_q;
  logic [NUM_SLV-1:0]  sel_hot, stale_q, stale_d;
  logic [31:0]         rsp_data_q, slot_data;
  logic [9:0]          fid_q;
  logic [31:0]         in0_q, in1_q;
  logic                cmd_ready_q;
  logic                accept, mapped, cmd_hs, rsp_hs, expire, timeout_fire;

  assign cmd_slot = cmd_function_id[CID_SEL_MSB -: SEL_W];
  assign mapped   = (32'(cmd_slot) < 32'(NUM_SLV));
  assign accept   = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;

  always_comb begin
    sel_hot   = '0;
    slot_data = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_hot[i] = (slot_q == SEL_W'(i));
      if (sel_hot[i]) slot_data = s_rsp_outputs_0[32*i +: 32];
    end
  end

  // A stale slot still owes a discarded response, so it is not offered new work.
  assign cmd_hs = |(sel_hot & s_cmd_ready & ~stale_q);
  assign rsp_hs = |(sel_hot & s_rsp_valid);

  cid_timeout_ctr #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (state_q == ST_IDLE),
    .en     ((state_q == ST_ISSUE) || (state_q == ST_WAIT)),
    .expire (expire)
  );

  always_comb begin
    state_d      = state_q;
    timeout_fire = 1'b0;
    case (state_q)
      ST_IDLE:  if (accept) state_d = mapped ? ST_ISSUE : ST_RESP;
      ST_ISSUE: begin
        if (cmd_hs) begin
          state_d = ST_WAIT;
        end else if (expire) begin
          state_d      = ST_RESP;
          timeout_fire = 1'b1;
        end
      end
      ST_WAIT: begin
        if (rsp_hs) begin
          state_d = ST_RESP;
        end else if (expire) begin
          state_d      = ST_RESP;
          timeout_fire = 1'b1;
        end
      end
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stale_d = stale_q & ~s_rsp_valid;
    if (timeout_fire) stale_d = stale_d | sel_hot;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      stale_q     <= '0;
      slot_q      <= '0;
      fid_q       <= '0;
      in0_q       <= '0;
      in1_q       <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      stale_q     <= stale_d;
      if (accept) begin
        slot_q <= cmd_slot;
        fid_q  <= cmd_function_id;
        in0_q  <= cmd_inputs_0;
        in1_q  <= cmd_inputs_1;
        if (!mapped) rsp_data_q <= ERR_DATA;
      end
      if ((state_q == ST_WAIT) && rsp_hs) rsp_data_q <= slot_data;
      if (timeout_fire) rsp_data_q <= ERR_DATA;
    end
  end

  assign cmd_ready         = cmd_ready_q;
  assign rsp_valid         = (state_q == ST_RESP);
  assign rsp_outputs_0     = rsp_data_q;
  assign busy              = (state_q != ST_IDLE);
  assign err_timeout       = timeout_fire;
  assign s_cmd_function_id = fid_q;
  assign s_cmd_inputs_0    = in0_q;
  assign s_cmd_inputs_1    = in1_q;
  assign s_cmd_valid       = (state_q == ST_ISSUE) ? (sel_hot & ~stale_q) : '0;
  assign s_rsp_ready       = stale_q | ((state_q == ST_WAIT) ? sel_hot : '0);

endmodule

// File: tb/tb_custom_instr_dispatcher.sv
// tb/tb_custom_instr_dispatcher.sv - scoreboard bench for custom_instr_dispatcher
module tb_custom_instr_dispatcher;

  localparam int          NS  = 3;
  localparam int          SW  = 2;
  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            cmd_valid = 1'b0;
  logic [9:0]      cmd_function_id = '0;
  logic [31:0]     cmd_inputs_0 = '0, cmd_inputs_1 = '0;
  logic            cmd_ready, rsp_valid;
  logic [31:0]     rsp_outputs_0;
  logic            rsp_ready = 1'b0;
  logic [NS-1:0]   s_cmd_valid, s_rsp_ready;
  logic [9:0]      s_cmd_function_id;
  logic [31:0]     s_cmd_inputs_0, s_cmd_inputs_1;
  logic [NS-1:0]   s_cmd_ready = '0, s_rsp_valid = '0;
  logic [32*NS-1:0] s_rsp_outputs_0 = '0;
  logic            busy, err_timeout;

  always #5 clk = ~clk;

  custom_instr_dispatcher #(.NUM_SLV(NS), .SEL_W(SW), .TIMEOUT_CYC(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_function_id(cmd_function_id),
    .cmd_inputs_0(cmd_inputs_0), .cmd_inputs_1(cmd_inputs_1), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_outputs_0(rsp_outputs_0), .rsp_ready(rsp_ready),
    .s_cmd_valid(s_cmd_valid), .s_cmd_function_id(s_cmd_function_id),
    .s_cmd_inputs_0(s_cmd_inputs_0), .s_cmd_inputs_1(s_cmd_inputs_1),
    .s_cmd_ready(s_cmd_ready), .s_rsp_valid(s_rsp_valid),
    .s_rsp_outputs_0(s_rsp_outputs_0), .s_rsp_ready(s_rsp_ready),
    .busy(busy), .err_timeout(err_timeout)
  );

  int          n_cmp = 0, n_bad = 0, cyc = 0;
  logic [31:0] exp_q[$];
  int          rr_mode = 0;
  int          err_cnt = 0, err_cyc = -1, rise_cyc = -1, rsp_hs_cyc = -1, acc_cyc = -1;
  int          cfg_rdy[NS], cfg_rsp[NS], slot_hs_cyc[NS];
  bit          pend[NS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Each slot computes a distinct function so misrouted data is visible.
  function automatic logic [31:0] slot_fn(input int i, input logic [31:0] a, input logic [31:0] b);
    case (i)
      0:       return a + b;
      1:       return a ^ {b[15:0], b[31:16]};
      default: return a - b;
    endcase
  endfunction

  function automatic logic [31:0] ref_rsp(input logic [9:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input bit hang);
    int s;
    s = int'(f[9:8]);
    if (s >= NS || hang) return ERR;
    return slot_fn(s, a, b);
  endfunction

  // CPU-side response monitor and rsp_ready driver.
  initial begin
    logic pv, pr, pe;
    logic [31:0] pd;
    logic [2:0] hot;
    pv = 1'b0; pr = 1'b0; pe = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      case (rr_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 9) < 7);
        default: rsp_ready = 1'b0;
      endcase
      if (!rstn) begin
        pv = 1'b0; pr = 1'b0; pe = 1'b0;
      end else begin
        if (err_timeout) begin
          err_cnt++;
          err_cyc = cyc;
          check("err_pulse_width", 128'(pe), 128'(0));
        end
        if (pv && !pr) begin
          check("rsp_hold_valid", 128'(rsp_valid), 128'(1));
          check("rsp_hold_data", 128'(rsp_outputs_0), 128'(pd));
        end
        if (rsp_valid && !pv) rise_cyc = cyc;
        if (rsp_valid && rsp_ready) begin
          rsp_hs_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_unexpected: got 0x%0h expected no response", rsp_outputs_0);
          end else begin
            check("rsp_data", 128'(rsp_outputs_0), 128'(exp_q.pop_front()));
          end
        end
        if (s_cmd_valid != '0) begin
          hot = 3'b001 << s_cmd_function_id[9:8];
          check("scv_onehot", 128'(s_cmd_valid), 128'(hot));
        end
        pv = rsp_valid; pr = rsp_ready; pd = rsp_outputs_0; pe = err_timeout;
      end
    end
  end

  // Accelerator slot models: configurable ready and response delays.
  initial begin
    logic [NS-1:0] p_scv, p_scr, p_srv, p_srr;
    logic [9:0]  cf[NS];
    logic [31:0] ca[NS], cb[NS], rd[NS];
    int dly[NS], rcnt[NS];
    p_scv = '0; p_scr = '0; p_srv = '0; p_srr = '0;
    for (int i = 0; i < NS; i++) begin
      cf[i] = '0; ca[i] = '0; cb[i] = '0; rd[i] = '0; dly[i] = 0; rcnt[i] = 0; pend[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (!rstn) begin
        s_cmd_ready = '0; s_rsp_valid = '0; s_rsp_outputs_0 = '0;
        p_scv = '0; p_scr = '0; p_srv = '0; p_srr = '0;
        for (int i = 0; i < NS; i++) begin
          pend[i] = 1'b0; dly[i] = 0; rcnt[i] = 0;
        end
      end else begin
        for (int i = 0; i < NS; i++) begin
          if (p_srv[i] && p_srr[i]) pend[i] = 1'b0;
          if (p_scv[i] && p_scr[i]) begin
            check("slot_sel", 128'(cf[i][9:8]), 128'(i));
            pend[i] = 1'b1;
            dly[i]  = cfg_rsp[i];
            rd[i]   = slot_fn(i, ca[i], cb[i]);
            rcnt[i] = 0;
          end else if (p_scv[i]) begin
            check("issue_hold", 128'({s_cmd_valid[i], s_cmd_function_id, s_cmd_inputs_0, s_cmd_inputs_1}),
                  128'({1'b1, cf[i], ca[i], cb[i]}));
          end
          if (pend[i] && dly[i] == 0) begin
            s_rsp_valid[i] = 1'b1;
            s_rsp_outputs_0[32*i +: 32] = rd[i];
          end else begin
            s_rsp_valid[i] = 1'b0;
            s_rsp_outputs_0[32*i +: 32] = $urandom;
            if (pend[i]) dly[i]--;
          end
          if (s_rsp_valid[i] && s_rsp_ready[i]) slot_hs_cyc[i] = cyc;
          s_cmd_ready[i] = !pend[i] && s_cmd_valid[i] && (rcnt[i] >= cfg_rdy[i]);
          if (s_cmd_valid[i] && !pend[i]) rcnt[i]++;
          cf[i] = s_cmd_function_id; ca[i] = s_cmd_inputs_0; cb[i] = s_cmd_inputs_1;
          p_scv[i] = s_cmd_valid[i]; p_scr[i] = s_cmd_ready[i];
          p_srv[i] = s_rsp_valid[i]; p_srr[i] = s_rsp_ready[i];
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance with cmd_valid still high.
  task automatic issue(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b, input bit hang);
    int n;
    cmd_valid = 1'b1; cmd_function_id = f; cmd_inputs_0 = a; cmd_inputs_1 = b;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_accept: got no cmd_ready within %0d cycles, required acceptance", n);
    end else begin
      exp_q.push_back(ref_rsp(f, a, b, hang));
      acc_cyc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b, input bit hang);
    issue(f, a, b, hang);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: got %0d pending responses busy=%0b, required 0 and idle", exp_q.size(), busy);
    end
  endtask

  function automatic logic [127:0] out_vec();
    return 128'({cmd_ready, rsp_valid, rsp_outputs_0, s_cmd_valid, s_cmd_function_id,
                 s_cmd_inputs_0, s_cmd_inputs_1, s_rsp_ready, busy, err_timeout});
  endfunction

  initial begin
    int a4;
    logic [1:0] s;
    for (int i = 0; i < NS; i++) begin
      cfg_rdy[i] = 0; cfg_rsp[i] = 0; slot_hs_cyc[i] = -1;
    end
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 128'(0));
    rstn = 1'b1;
    @(negedge clk);
    check("reset_cmd_ready", 128'(cmd_ready), 128'(1));
    check("reset_busy", 128'(busy), 128'(0));

    // Slot 0 answers a few cycles after accepting.
    cfg_rsp[0] = 3;
    send(10'h005, 32'h0000_1000, 32'h0000_0234, 1'b0);
    check("t1_scv_latency", 128'(s_cmd_valid), 128'(3'b001));
    wait_idle();
    check("t1_rsp_latency", 128'(rise_cyc), 128'(slot_hs_cyc[0] + 1));

    // Slot 2 stalls its command ready.
    cfg_rdy[2] = 5; cfg_rsp[2] = 1;
    send(10'h201, 32'hCAFE_0001, 32'h0000_0101, 1'b0);
    wait_idle();
    cfg_rdy[2] = 0;

    // CPU stalls the response while the next command waits.
    rr_mode = 2;
    issue(10'h011, 32'h1111_0000, 32'h0000_2222, 1'b0);
    fork
      issue(10'h112, 32'h5A5A_5A5A, 32'h0F0F_1234, 1'b0);
      begin
        int n;
        n = 0;
        while (!rsp_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("t3_cmd_ready_low", 128'(cmd_ready), 128'(0));
        end
        rr_mode = 0;
      end
    join
    cmd_valid = 1'b0;
    check("t3_next_accept", 128'(acc_cyc), 128'(rsp_hs_cyc + 1));
    wait_idle();

    // Slot 0 goes silent past the timeout, then answers late.
    cfg_rsp[0] = 25;
    send(10'h0AA, 32'h0000_0001, 32'h0000_0002, 1'b1);
    a4 = acc_cyc;
    wait_idle();
    check("t4_err_cycle", 128'(err_cyc), 128'(a4 + TO));
    check("t4_err_count", 128'(err_cnt), 128'(1));
    repeat (40) @(negedge clk);
    check("t4_drained", 128'({pend[0], s_rsp_ready}), 128'(0));
    cfg_rsp[0] = 1;
    send(10'h0AB, 32'h0000_7000, 32'h0000_0777, 1'b0);
    wait_idle();

    // Unmapped slot returns the error word without touching any slot.
    send(10'h300, 32'h0000_0042, 32'h0000_0043, 1'b0);
    check("t5_no_scv", 128'(s_cmd_valid), 128'(0));
    wait_idle();

    // Reset while waiting for a slot response.
    cfg_rsp[1] = 10;
    send(10'h1C3, 32'h0BAD_F00D, 32'h1357_9BDF, 1'b0);
    repeat (4) @(negedge clk);
    check("t6_busy", 128'(busy), 128'(1));
    rstn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t6_reset_outputs", out_vec(), 128'(0));
    rstn = 1'b1;
    @(negedge clk);
    check("t6_cmd_ready", 128'(cmd_ready), 128'(1));
    cfg_rsp[1] = 2;
    send(10'h1C4, 32'h2468_ACE0, 32'h0000_FFFF, 1'b0);
    wait_idle();

    // Randomized traffic with bounded slot delays and random CPU back-pressure.
    rr_mode = 1;
    for (int t = 0; t < 40; t++) begin
      s = 2'($urandom_range(0, 3));
      if (s < 2'd3) begin
        cfg_rdy[s] = $urandom_range(0, 3);
        cfg_rsp[s] = $urandom_range(0, 4);
      end
      send({s, 8'($urandom)}, $urandom, $urandom, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    check("err_total", 128'(err_cnt), 128'(1));
    check("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
